// File: rtl/fir_tap_loader_if.sv
// Tap-load stream between the loader (master) and the FIR tap port (slave).
// The slave answers each word with ready and raises a level done once the whole table has been taken.
interface fir_tap_loader_if #(
  parameter int G_TAP_WIDTH = 16
);
  logic [G_TAP_WIDTH-1:0] tap_dout;
  logic                   tap_dout_valid;
  logic                   tap_dout_ready;
  logic                   tap_done_in;

  modport master (
    output tap_dout,
    output tap_dout_valid,
    input  tap_dout_ready,
    input  tap_done_in
  );

  modport slave (
    input  tap_dout,
    input  tap_dout_valid,
    output tap_dout_ready,
    output tap_done_in
  );
endinterface

// File: rtl/fir_tap_loader.sv
// FIR tap loader: local tap table written while idle, streamed in address order on load_start,
// then waits for the FIR's done level with an optional timeout.
module fir_tap_loader #(
  parameter int G_TAP_WIDTH     = 16,
  parameter int G_NUM_TAPS_LOG2 = 4,
  parameter int G_DONE_TIMEOUT  = 1024
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [G_NUM_TAPS_LOG2-1:0] tap_wr_addr,
  input  logic [G_TAP_WIDTH-1:0]     tap_wr_data,
  input  logic                       tap_wr_en,
  output logic                       tap_wr_ignored,
  input  logic                       load_start,
  output logic                       busy,
  output logic                       load_done,
  output logic                       load_error,
  output logic [G_NUM_TAPS_LOG2:0]   tap_count,
  fir_tap_loader_if.master           tap
);

  localparam int N    = 1 << G_NUM_TAPS_LOG2;
  localparam int CW   = G_NUM_TAPS_LOG2 + 1;
  localparam int TO_W = (G_DONE_TIMEOUT > 1) ? $clog2(G_DONE_TIMEOUT) : 1;
  localparam bit TO_EN = (G_DONE_TIMEOUT > 0);
  localparam logic [TO_W-1:0]            TO_LAST   = TO_W'((G_DONE_TIMEOUT > 0) ? G_DONE_TIMEOUT - 1 : 0);
  localparam logic [CW-1:0]              COUNT_MAX = CW'(N);
  localparam logic [G_NUM_TAPS_LOG2-1:0] IDX_LAST  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  state_t                     state_reg;
  logic [G_TAP_WIDTH-1:0]     mem [N];
  logic [G_NUM_TAPS_LOG2-1:0] idx_reg;
  logic [TO_W-1:0]            to_cnt_reg;
  logic [CW-1:0]              count_reg;
  logic                       busy_reg;
  logic                       valid_reg;
  logic                       done_reg;
  logic                       error_reg;
  logic                       ignored_reg;
  logic                       wr_accept;

  // Only an enabled, idle loader may touch the table, so the word under an
  // outstanding valid can never change.
  assign wr_accept = tap_wr_en && enable && (state_reg == S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_accept) begin
      mem[tap_wr_addr] <= tap_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      idx_reg     <= '0;
      to_cnt_reg  <= '0;
      count_reg   <= '0;
      busy_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      done_reg    <= 1'b0;
      error_reg   <= 1'b0;
      ignored_reg <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      ignored_reg <= tap_wr_en && !wr_accept;
      if (!enable) begin
        // Abort: tap_count, load_error and the table are deliberately kept.
        state_reg <= S_IDLE;
        busy_reg  <= 1'b0;
        valid_reg <= 1'b0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (load_start) begin
              idx_reg    <= '0;
              count_reg  <= '0;
              error_reg  <= 1'b0;
              to_cnt_reg <= '0;
              busy_reg   <= 1'b1;
              valid_reg  <= 1'b1;
              state_reg  <= S_STREAM;
            end
          end
          S_STREAM: begin
            if (tap.tap_dout_ready) begin
              if (count_reg != COUNT_MAX) begin
                count_reg <= count_reg + 1'b1;
              end
              if (idx_reg == IDX_LAST) begin
                valid_reg  <= 1'b0;
                to_cnt_reg <= '0;
                state_reg  <= S_WAIT_DONE;
              end else begin
                idx_reg <= idx_reg + 1'b1;
              end
            end
          end
          S_WAIT_DONE: begin
            // Done wins over a timeout expiring on the same edge.
            if (tap.tap_done_in) begin
              done_reg  <= 1'b1;
              state_reg <= S_DONE;
            end else if (TO_EN && (to_cnt_reg == TO_LAST)) begin
              error_reg <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= S_IDLE;
            end else begin
              to_cnt_reg <= to_cnt_reg + 1'b1;
            end
          end
          S_DONE: begin
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end
          default: begin
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
            state_reg <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign tap.tap_dout       = valid_reg ? mem[idx_reg] : '0;
  assign tap.tap_dout_valid = valid_reg;
  assign busy               = busy_reg;
  assign load_done          = done_reg;
  assign load_error         = error_reg;
  assign tap_wr_ignored     = ignored_reg;
  assign tap_count          = count_reg;

endmodule

// File: doc/fir_tap_loader.md
Name: fir_tap_loader

Overview:
- Initiator side of the FIR tap-load handshake (tap_din/tap_din_valid/tap_din_ready/tap_din_done on configurable_fir and on the wrappers around it, e.g. the reverb path).
- Holds a local tap table written by a control source, then on command streams all taps in address order into the FIR tap port.
- Waits for the FIR's done indication and reports completion or timeout.

Parameters:
- G_TAP_WIDTH, 16, tap word width; must match the FIR G_TAP_WIDTH.
- G_NUM_TAPS_LOG2, 4, log2 of the tap count N. Set equal to the FIR G_NUM_STAGES_LOG2+G_STAGE_DEPTH_LOG2.
- G_DONE_TIMEOUT, 1024, cycles allowed in WAIT_DONE before error. 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  block enable; low forces IDLE synchronously
- tap_wr_addr  in  G_NUM_TAPS_LOG2  table write address
- tap_wr_data  in  G_TAP_WIDTH  table write data
- tap_wr_en  in  1  table write strobe
- tap_wr_ignored  out  1  one-cycle pulse: write dropped because not IDLE
- load_start  in  1  start streaming; sampled only in IDLE
- busy  out  1  high in any state other than IDLE
- load_done  out  1  one-cycle pulse on successful completion
- load_error  out  1  sticky timeout flag; cleared by an accepted load_start
- tap_count  out  G_NUM_TAPS_LOG2+1  number of taps accepted in the current or last load
- tap_dout  out  G_TAP_WIDTH  tap word to FIR tap_din
- tap_dout_valid  out  1  to FIR tap_din_valid
- tap_dout_ready  in  1  from FIR tap_din_ready
- tap_done_in  in  1  from FIR tap_din_done (level)

Behaviour:
- Reset (reset_n low, async):
  - state = IDLE.
  - All outputs 0: busy, load_done, load_error, tap_wr_ignored, tap_dout_valid, tap_count.
  - tap_dout = 0; tap table cleared to 0; index and timeout counters cleared.
- Table writes: when tap_wr_en=1 in IDLE with enable=1, mem[tap_wr_addr] <= tap_wr_data at the clock edge. In any other state the write is dropped and tap_wr_ignored pulses the next cycle.
- States:
  - IDLE: on load_start=1 and enable=1: idx <= 0, tap_count <= 0, load_error <= 0, go to STREAM.
  - STREAM:
    - tap_dout_valid = 1; tap_dout = mem[idx] (combinational read of the registered index).
    - On tap_dout_valid & tap_dout_ready: tap_count++. If idx = N-1, go to WAIT_DONE; else idx++.
    - tap_dout must stay stable while valid=1 and ready=0. Valid never drops without a handshake, except on enable low or reset.
    - Throughput is 1 tap/cycle when ready is held high.
  - WAIT_DONE:
    - tap_dout_valid = 0; the timeout counter increments each cycle.
    - tap_done_in=1 -> DONE. This has priority over a timeout expiring in the same cycle.
    - Counter reaching G_DONE_TIMEOUT (when nonzero) -> load_error <= 1, go to IDLE.
  - DONE: load_done = 1 for exactly this cycle, then IDLE.
- Latency:
  - load_start at edge T -> first valid at T+1.
  - Last handshake at edge L -> WAIT_DONE from L+1.
  - tap_done_in high at L+1 -> load_done at L+2.
- tap_done_in is ignored outside WAIT_DONE. A stale high level from a previous load completes WAIT_DONE on its first cycle; the system must reset or re-enable the FIR between loads when that matters.
- Extra load_start pulses while busy are ignored.
- enable low mid-operation: next edge -> IDLE, valid=0, busy=0, no load_done. tap_count and load_error are held; table contents are retained.
- tap_count saturates at N; it cannot exceed N by construction.

Test Plan:
- Write mem[i]=0x1000+i for i=0..15 in IDLE, pulse load_start, hold ready=1 -> tap_dout = 0x1000..0x100F on 16 consecutive cycles starting the cycle after start; tap_count=16; tap_done_in high 3 cycles later -> load_done single pulse; busy drops the following cycle.
- Same table, ready toggling 1,0,0,1 repeating -> each word held stable across stalls; no word skipped or repeated; 16 handshakes total.
- G_DONE_TIMEOUT=8, tap_done_in never asserted -> load_error=1 exactly 8 cycles after entry to WAIT_DONE; state IDLE; no load_done; next load_start clears load_error.
- tap_wr_en with addr 3, data 0xBEEF while in STREAM -> tap_wr_ignored pulse; a later load still emits the old mem[3].
- enable dropped after 5 handshakes -> valid=0 next cycle, busy=0, tap_count=5; re-enable and restart -> full 16-tap sequence from address 0.
- reset_n asserted mid-STREAM, asynchronously between edges -> all outputs 0 immediately; after release, a load streams all-zero taps.
